// File: rtl/comp_mul_seq.sv
// Radix-2 shift-add multiplier (unsigned or signed via sign-magnitude); WIDTH+1 busy cycles from accept to result.
// Accepts run only while ready=1; requests during a busy operation are dropped, never queued.
module comp_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   Multiplicand_input,
  input  logic [WIDTH-1:0]   Multiplier_input,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] Product_output
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;

  // Signed operands are reduced to magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits.
  always_comb begin
    a_mag = (sgn && Multiplicand_input[WIDTH-1]) ? -Multiplicand_input : Multiplicand_input;
    b_mag = (sgn && Multiplier_input[WIDTH-1])   ? -Multiplier_input   : Multiplier_input;
  end

  // The carry out of the partial add lives in sum[WIDTH] and drops into hi's MSB on the shift.
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          mcand_d = a_mag;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          neg_d   = sgn & (Multiplicand_input[WIDTH-1] ^ Multiplier_input[WIDTH-1]);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        prod_d  = neg_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign ready          = (state_q == IDLE);
  assign done           = done_q;
  assign Product_output = prod_q;

endmodule

// File: tb/tb_comp_mul_seq.sv
// Bench for comp_mul_seq at WIDTH=32 and WIDTH=8: vector table, hand-written corner sequences, random ops vs arithmetic model.
module tb_comp_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run32, sgn32, rdy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;
  logic        run8, sgn8, rdy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  comp_mul_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .run(run32), .sgn(sgn32),
    .Multiplicand_input(a32), .Multiplier_input(b32),
    .ready(rdy32), .done(done32), .Product_output(prod32)
  );

  comp_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .run(run8), .sgn(sgn8),
    .Multiplicand_input(a8), .Multiplier_input(b8),
    .ready(rdy8), .done(done8), .Product_output(prod8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'({32'b0, a});
    y = s ? longint'($signed(b)) : longint'({32'b0, b});
    return x * y;
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x, y;
    x = s ? int'($signed(a)) : int'({24'b0, a});
    y = s ? int'($signed(b)) : int'({24'b0, b});
    return 16'(x * y);
  endfunction

  // Called just after an edge with ready=1; returns in the cycle where done should be high.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s, input bit disturb,
                      output logic [63:0] p, output int low, output int dn, output int chg);
    logic [63:0] p0;
    a32 = a; b32 = b; sgn32 = s; run32 = 1'b1;
    @(posedge clk); #1;
    run32 = 1'b0;
    low = 0; dn = 0; chg = 0; p0 = prod32;
    while (!rdy32 && low < 200) begin
      low++;
      if (done32) dn++;
      if (prod32 !== p0) chg++;
      if (disturb) begin
        run32 = 1'($urandom); a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    run32 = 1'b0;
    if (done32) dn++;
    p = prod32;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [15:0] p, output int low, output int dn);
    a8 = a; b8 = b; sgn8 = s; run8 = 1'b1;
    @(posedge clk); #1;
    run8 = 1'b0;
    low = 0; dn = 0;
    while (!rdy8 && low < 100) begin
      low++;
      if (done8) dn++;
      @(posedge clk); #1;
    end
    if (done8) dn++;
    p = prod8;
  endtask

  logic [63:0] p;
  logic [15:0] p8;
  logic [31:0] ra, rb;
  logic [7:0]  ra8, rb8;
  logic        rs;
  int          low, dn, chg;

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    vecs[1] = '{32'd94,       32'd2647,     1'b0, 64'h000000000003CBF2};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFFFFFFFFFE};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b0, 64'h0000000000000000};
    vecs[7] = '{32'h00000000, 32'hFFFFFFF3, 1'b1, 64'h0000000000000000};

    rst = 1'b1; run32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    run8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(rdy32), 64'd1);
    chk("reset_done", 64'(done32), 64'd0);
    chk("reset_prod", prod32, 64'd0);
    chk("reset_prod8", 64'(prod8), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table ops are issued back-to-back: each run is raised in the done cycle of the previous one.
    for (int i = 0; i < 8; i++) begin
      op32(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, p, low, dn, chg);
      chk($sformatf("vec%0d_prod", i), p, vecs[i].exp);
      chk($sformatf("vec%0d_ready_low", i), 64'(low), 64'd33);
      chk($sformatf("vec%0d_done_count", i), 64'(dn), 64'd1);
      chk($sformatf("vec%0d_prod_held", i), 64'(chg), 64'd0);
    end
    @(posedge clk); #1;
    chk("done_pulse_ends", 64'(done32), 64'd0);

    op32(32'd123456, 32'd789, 1'b0, 1'b1, p, low, dn, chg);
    chk("busy_disturb_prod", p, 64'd97406784);
    chk("busy_disturb_done_count", 64'(dn), 64'd1);
    chk("busy_disturb_ready_low", 64'(low), 64'd33);
    @(posedge clk); #1;
    chk("busy_disturb_idle_after", 64'(rdy32), 64'd1);

    a32 = 32'hDEADBEEF; b32 = 32'h12345678; sgn32 = 1'b0; run32 = 1'b1;
    @(posedge clk); #1;
    run32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midcalc_busy", 64'(rdy32), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midcalc_rst_ready", 64'(rdy32), 64'd1);
    chk("midcalc_rst_prod", prod32, 64'd0);
    chk("midcalc_rst_done", 64'(done32), 64'd0);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) dn++;
    end
    chk("midcalc_no_done", 64'(dn), 64'd0);
    op32(32'd7, 32'd6, 1'b0, 1'b0, p, low, dn, chg);
    chk("after_rst_7x6", p, 64'd42);
    @(posedge clk); #1;

    a32 = 32'd5; b32 = 32'd5; run32 = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; run32 = 1'b0;
    chk("rst_run_idle", 64'(rdy32), 64'd1);
    @(posedge clk); #1;
    chk("rst_run_still_idle", 64'(rdy32), 64'd1);
    chk("rst_run_no_done", 64'(done32), 64'd0);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 32'h0;
        1:       ra = 32'h80000000;
        2:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      rs = 1'($urandom);
      op32(ra, rb, rs, 1'b0, p, low, dn, chg);
      chk($sformatf("rand%0d_%h_x_%h_s%0d", i, ra, rb, rs), p, model32(ra, rb, rs));
      chk($sformatf("rand%0d_done_count", i), 64'(dn), 64'd1);
    end
    @(posedge clk); #1;

    op8(8'd255, 8'd255, 1'b0, p8, low, dn);
    chk("w8_255x255", 64'(p8), 64'd65025);
    chk("w8_ready_low", 64'(low), 64'd9);
    chk("w8_done_count", 64'(dn), 64'd1);
    op8(8'h80, 8'h7F, 1'b1, p8, low, dn);
    chk("w8_m128x127", 64'(p8), 64'h000000000000C080);
    for (int i = 0; i < 12; i++) begin
      ra8 = 8'($urandom);
      rb8 = 8'($urandom);
      rs  = 1'($urandom);
      op8(ra8, rb8, rs, p8, low, dn);
      chk($sformatf("w8_rand%0d_%h_x_%h_s%0d", i, ra8, rb8, rs), 64'(p8), 64'(model8(ra8, rb8, rs)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
